audio_level_meter: RTL and testbench
====================================

# audio_level_meter

Parametrised, pipelined audio level meter that converts signed codec samples into a log-scaled LED bar graph. It sits between the Audio_Controller's input sample stream and the board LEDs, in parallel with the tuner FFT path. It adds selectable channel source, peak-hold and decaying-bar display modes, and a sticky clip indicator. Display timers count audio samples, not clocks.

## Interface

- SAMPLE_W, 32: signed sample width.
- NUM_LEDS, 10: bar length; `level` range 0..NUM_LEDS.
- BASE_EXP, 18: threshold k (k=1..NUM_LEDS) is 2^(BASE_EXP+k-1); requires BASE_EXP+NUM_LEDS-1 ≤ SAMPLE_W-2.
- HOLD_SAMPLES, 24000: samples a peak is held before decaying.
- DECAY_SAMPLES, 2400: samples per one-level decay step.
- CLIP_SAMPLES, 48000: samples the clip flag stays asserted after the last clipping sample.

- clk, in, 1: system clock (CLOCK_50 at top level).
- reset_n, in, 1: asynchronous, active-low reset.
- sample_valid, in, 1: one-cycle strobe; left/right are valid.
- left_in, in, SAMPLE_W: signed left sample.
- right_in, in, SAMPLE_W: signed right sample.
- ch_sel, in, 2: 0 = left, 1 = right, 2 and 3 = max(|L|,|R|).
- mode, in, 2: 0 = instantaneous bar, 1 = bar + peak-hold dot, 2 and 3 = decaying bar.
- leds, out, NUM_LEDS: LED pattern; bit 0 is the lowest segment.
- level, out, clog2(NUM_LEDS+1): displayed bar height.
- clip, out, 1: sticky clip indicator.
- out_valid, out, 1: pulses when leds/level update.

## Operation

- Stage 1, on sample_valid:
  - Register magnitudes |L| and |R| as SAMPLE_W-1 unsigned values.
  - The most negative input saturates to 2^(SAMPLE_W-1)-1.
  - Capture ch_sel and mode with the sample.
- Stage 2:
  - mag = selected magnitude per ch_sel.
  - inst = count of thresholds k with mag > 2^(BASE_EXP+k-1), using strict greater-than.
  - clip_hit = (mag ≥ 2^(SAMPLE_W-1)-1).
- Stage 3: display state update, one step per valid sample.
  - Decay counter: dcnt counts 0..DECAY_SAMPLES-1 and wraps. A step occurs when dcnt wraps.
  - Peak register (modes 1 and 2):
    - If inst ≥ peak: set peak = inst and reload hcnt = HOLD_SAMPLES.
    - Else if hcnt > 0: decrement hcnt.
    - Else, on a decay step: peak = peak-1, saturating at 0.
  - Mode 0: level = inst; leds = inst lowest bits set.
  - Mode 1: level = inst; leds = bar(inst) OR one-hot bit (peak-1) when peak > 0.
  - Mode 2: level = peak; leds = bar(peak).
  - Clip: clip_hit reloads ccnt = CLIP_SAMPLES and sets clip. Otherwise ccnt decrements per sample; clip clears when ccnt reaches 0.
- Mode and ch_sel changes:
  - They take effect on the next sample.
  - Peak and hold state are kept across mode changes; peak is tracked in all modes.
- No sample_valid: all state frozen; outputs hold.

## Timing

- Latency: sample_valid in cycle N gives out_valid, leds and level updated in cycle N+3.
- Pipeline: fully pipelined; sample_valid on consecutive cycles is accepted, one result per cycle.
- Handshake: none; the block never stalls, and sample_valid is never dropped.
- Reset: asynchronous assertion clears everything to 0: leds, level, clip, out_valid, peak, hcnt, dcnt, ccnt, and all pipeline valids.
  - Reset mid-pipeline discards in-flight samples.
  - First output after release follows the first post-reset sample_valid by 3 cycles.
- Simultaneous events: a new peak (inst ≥ peak) on a decay-step sample takes the new peak; the decay is lost and dcnt still advances.
- Saturation boundaries:
  - peak does not drop below 0 or exceed NUM_LEDS.
  - hcnt and ccnt do not underflow.

## Test plan

Bench parameters: HOLD_SAMPLES=4, DECAY_SAMPLES=2, CLIP_SAMPLES=3, with other parameters at default.

- **Threshold edges, mode 0, ch_sel 0:**
  - left_in = 0x00040000 (2^18) gives level 0, leds 0x000.
  - 0x00040001 gives level 1, leds 0x001.
  - 0x08000001 gives level 10, leds 0x3FF.
  - Each result appears exactly 3 cycles after its strobe.
- **Sign and saturation, ch_sel 2:**
  - left = -0x00100001, right = 0x10 gives level 3, leds 0x007.
  - left = 0x80000000 gives clip = 1 and level 10.
- **Peak hold, mode 1:**
  - Send one sample at level 6, then 0 on every following sample.
  - leds = 0x020 for 4 samples.
  - Peak then falls one level every 2 samples: 0x010, 0x008, and so on, reaching leds 0x000.
- **Decay, mode 2:**
  - Send one sample at level 10, then zeros.
  - level stays 10 for 4 samples, then 9, 9, 8, 8, ... down to 0, then stays 0.
- **Clip stretch:**
  - One clipping sample, then quiet samples.
  - clip stays high for 3 samples after the clipping sample, then clears.
  - A second clip inside that window restarts the count.
- **Back-to-back and reset:**
  - Apply 8 consecutive-cycle strobes: 8 consecutive out_valid pulses with matching levels.
  - Drop reset_n mid-stream: all outputs 0 immediately, and no stale out_valid after release.

Source files
------------

// File: rtl/audio_level_meter.sv
// audio_level_meter
//   Converts signed codec samples into a log-scaled LED bar graph with
//   selectable channel source, peak-hold / decaying display modes and a
//   sticky clip indicator. Three-stage pipeline, one sample per cycle.
//   All display timers count audio samples, not clocks.
//
// Ports
//   clk          : system clock
//   reset_n      : asynchronous active-low reset
//   sample_valid : one-cycle strobe, left_in/right_in valid
//   left_in      : signed left sample
//   right_in     : signed right sample
//   ch_sel       : 0 left, 1 right, 2/3 max(|L|,|R|)
//   mode         : 0 instantaneous bar, 1 bar + peak dot, 2/3 decaying bar
//   leds         : LED pattern, bit 0 is the lowest segment
//   level        : displayed bar height 0..NUM_LEDS
//   clip         : sticky clip indicator
//   out_valid    : pulses when leds/level update (3 cycles after strobe)
module audio_level_meter #(
    parameter int SAMPLE_W      = 32,
    parameter int NUM_LEDS      = 10,
    parameter int BASE_EXP      = 18,
    parameter int HOLD_SAMPLES  = 24000,
    parameter int DECAY_SAMPLES = 2400,
    parameter int CLIP_SAMPLES  = 48000,
    localparam int LVL_W        = $clog2(NUM_LEDS + 1)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] left_in,
    input  logic signed [SAMPLE_W-1:0] right_in,
    input  logic [1:0]                 ch_sel,
    input  logic [1:0]                 mode,
    output logic [NUM_LEDS-1:0]        leds,
    output logic [LVL_W-1:0]           level,
    output logic                       clip,
    output logic                       out_valid
);

    localparam int MAG_W  = SAMPLE_W - 1;
    localparam int HCNT_W = $clog2(HOLD_SAMPLES + 1);
    localparam int CCNT_W = $clog2(CLIP_SAMPLES + 1);
    localparam int DCNT_W = (DECAY_SAMPLES > 1) ? $clog2(DECAY_SAMPLES) : 1;

    // Absolute value; the most negative code has no positive twin and
    // saturates to full scale.
    function automatic logic [MAG_W-1:0] abs_sat(input logic signed [SAMPLE_W-1:0] x);
        logic [SAMPLE_W-1:0] neg;
        if (!x[SAMPLE_W-1])
            return x[MAG_W-1:0];
        neg = -x;
        if (neg[SAMPLE_W-1])
            return '1;
        return neg[MAG_W-1:0];
    endfunction

    // Number of thresholds 2^(BASE_EXP+k-1) strictly exceeded.
    function automatic logic [LVL_W-1:0] log_level(input logic [MAG_W-1:0] m);
        logic [LVL_W-1:0] n;
        n = '0;
        for (int k = 1; k <= NUM_LEDS; k++) begin
            if (m > (MAG_W'(1) << (BASE_EXP + k - 1)))
                n = n + 1'b1;
        end
        return n;
    endfunction

    function automatic logic [NUM_LEDS-1:0] bar(input logic [LVL_W-1:0] n);
        logic [NUM_LEDS-1:0] b;
        for (int i = 0; i < NUM_LEDS; i++)
            b[i] = (i < int'(n));
        return b;
    endfunction

    function automatic logic [NUM_LEDS-1:0] dot(input logic [LVL_W-1:0] n);
        logic [NUM_LEDS-1:0] d;
        for (int i = 0; i < NUM_LEDS; i++)
            d[i] = (int'(n) == i + 1);
        return d;
    endfunction

    logic             vld_p0, vld_p1;
    logic [MAG_W-1:0] mag_l_p0, mag_r_p0;
    logic [1:0]       ch_sel_p0, mode_p0, mode_p1;
    logic [MAG_W-1:0] mag_sel;
    logic [LVL_W-1:0] inst_p1;
    logic             hit_p1;

    logic [LVL_W-1:0]  peak, peak_nxt;
    logic [HCNT_W-1:0] hcnt, hcnt_nxt;
    logic [DCNT_W-1:0] dcnt, dcnt_nxt;
    logic [CCNT_W-1:0] ccnt, ccnt_nxt;
    logic              clip_nxt, step;
    logic [NUM_LEDS-1:0] leds_nxt;
    logic [LVL_W-1:0]  level_nxt;

    // ---- stage 1: magnitudes and per-sample controls ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            vld_p0 <= 1'b0;
        else
            vld_p0 <= sample_valid;
    end

    always_ff @(posedge clk) begin
        if (sample_valid) begin
            mag_l_p0  <= abs_sat(left_in);
            mag_r_p0  <= abs_sat(right_in);
            ch_sel_p0 <= ch_sel;
            mode_p0   <= mode;
        end
    end

    // ---- stage 2: channel select, log level, clip detect ----
    always_comb begin
        mag_sel = mag_l_p0;
        case (ch_sel_p0)
            2'd0:    mag_sel = mag_l_p0;
            2'd1:    mag_sel = mag_r_p0;
            default: mag_sel = (mag_l_p0 > mag_r_p0) ? mag_l_p0 : mag_r_p0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= vld_p0;
    end

    always_ff @(posedge clk) begin
        if (vld_p0) begin
            inst_p1 <= log_level(mag_sel);
            hit_p1  <= &mag_sel;
            mode_p1 <= mode_p0;
        end
    end

    // ---- stage 3: peak/hold/decay/clip state and display ----
    always_comb begin
        step     = (dcnt == DCNT_W'(DECAY_SAMPLES - 1));
        dcnt_nxt = step ? '0 : dcnt + 1'b1;
        peak_nxt = peak;
        hcnt_nxt = hcnt;
        // A new peak wins over a coincident decay step.
        if (inst_p1 >= peak) begin
            peak_nxt = inst_p1;
            hcnt_nxt = HCNT_W'(HOLD_SAMPLES);
        end else if (hcnt != '0) begin
            hcnt_nxt = hcnt - 1'b1;
        end else if (step && (peak != '0)) begin
            peak_nxt = peak - 1'b1;
        end

        // clip stays up while the stretch counter is still running down
        ccnt_nxt = ccnt;
        clip_nxt = 1'b0;
        if (hit_p1) begin
            ccnt_nxt = CCNT_W'(CLIP_SAMPLES);
            clip_nxt = 1'b1;
        end else if (ccnt != '0) begin
            ccnt_nxt = ccnt - 1'b1;
            clip_nxt = 1'b1;
        end

        level_nxt = inst_p1;
        leds_nxt  = bar(inst_p1);
        case (mode_p1)
            2'd0: begin
                level_nxt = inst_p1;
                leds_nxt  = bar(inst_p1);
            end
            2'd1: begin
                level_nxt = inst_p1;
                leds_nxt  = bar(inst_p1) | dot(peak_nxt);
            end
            default: begin
                level_nxt = peak_nxt;
                leds_nxt  = bar(peak_nxt);
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            leds      <= '0;
            level     <= '0;
            clip      <= 1'b0;
            peak      <= '0;
            hcnt      <= '0;
            dcnt      <= '0;
            ccnt      <= '0;
        end else begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                leds  <= leds_nxt;
                level <= level_nxt;
                clip  <= clip_nxt;
                peak  <= peak_nxt;
                hcnt  <= hcnt_nxt;
                dcnt  <= dcnt_nxt;
                ccnt  <= ccnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_audio_level_meter.sv
// Testbench for audio_level_meter: directed vectors, a sample-indexed
// behavioural model with a per-cycle compare process, and literal checks.
module tb_audio_level_meter;

    localparam int HOLD  = 4;
    localparam int DECAY = 2;
    localparam int CLIPN = 3;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               sample_valid = 1'b0;
    logic signed [31:0] left_in = '0;
    logic signed [31:0] right_in = '0;
    logic [1:0]         ch_sel = '0;
    logic [1:0]         mode = '0;
    logic [9:0]         leds;
    logic [3:0]         level;
    logic               clip;
    logic               out_valid;

    audio_level_meter #(
        .SAMPLE_W(32), .NUM_LEDS(10), .BASE_EXP(18),
        .HOLD_SAMPLES(HOLD), .DECAY_SAMPLES(DECAY), .CLIP_SAMPLES(CLIPN)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid),
        .left_in(left_in), .right_in(right_in), .ch_sel(ch_sel), .mode(mode),
        .leds(leds), .level(level), .clip(clip), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int due;
        int leds;
        int level;
        int clip;
    } exp_t;

    exp_t q[$];
    exp_t last;
    exp_t e_cmp;
    int   m_n, m_peak, m_last_set, m_last_clip;

    function automatic longint mag_of(input logic signed [31:0] v);
        longint x;
        x = longint'(v);
        if (x < 0) x = -x;
        if (x > 64'sd2147483647) x = 64'sd2147483647;
        return x;
    endfunction

    function automatic int lvl_of(input longint m);
        int n = 0;
        for (int k = 1; k <= 10; k++)
            if (m > (longint'(1) << (18 + k - 1))) n++;
        return n;
    endfunction

    function automatic int bar_of(input int n);
        return (1 << n) - 1;
    endfunction

    task automatic model_reset();
        q.delete();
        last = '{0, 0, 0, 0};
        m_n = 0;
        m_peak = 0;
        m_last_set = -1000000;
        m_last_clip = -1000000;
    endtask

    task automatic model_push(input logic signed [31:0] l, input logic signed [31:0] r,
                              input logic [1:0] cs, input logic [1:0] md, input int due);
        longint ml, mr, m;
        int     inst;
        bit     is_step;
        exp_t   e;
        ml = mag_of(l);
        mr = mag_of(r);
        m  = (cs == 2'd0) ? ml : (cs == 2'd1) ? mr : ((ml > mr) ? ml : mr);
        inst = lvl_of(m);
        is_step = ((m_n % DECAY) == DECAY - 1);
        if (inst >= m_peak) begin
            m_peak = inst;
            m_last_set = m_n;
        end else if ((m_n - m_last_set) > HOLD && is_step && m_peak > 0) begin
            m_peak = m_peak - 1;
        end
        if (m >= 64'sd2147483647) m_last_clip = m_n;
        e.due  = due;
        e.clip = ((m_n - m_last_clip) <= CLIPN) ? 1 : 0;
        if (md == 2'd0) begin
            e.level = inst;
            e.leds  = bar_of(inst);
        end else if (md == 2'd1) begin
            e.level = inst;
            e.leds  = bar_of(inst) | ((m_peak > 0) ? (1 << (m_peak - 1)) : 0);
        end else begin
            e.level = m_peak;
            e.leds  = bar_of(m_peak);
        end
        q.push_back(e);
        m_n++;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due < cyc) begin
            checks++;
            failures++;
            $display("FAIL latency missed_output due=%0d now=%0d", q[0].due, cyc);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            e_cmp = q.pop_front();
            check("out_valid", {31'd0, out_valid}, 32'd1);
            check("leds", {22'd0, leds}, e_cmp.leds);
            check("level", {28'd0, level}, e_cmp.level);
            check("clip", {31'd0, clip}, e_cmp.clip);
            last = e_cmp;
        end else begin
            check("out_valid_idle", {31'd0, out_valid}, 32'd0);
            check("leds_hold", {22'd0, leds}, last.leds);
            check("level_hold", {28'd0, level}, last.level);
            check("clip_hold", {31'd0, clip}, last.clip);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at posedge+1; leaves sample_valid high and returns at next posedge+1.
    task automatic drive(input logic [31:0] l, input logic [31:0] r,
                         input logic [1:0] cs, input logic [1:0] md);
        left_in = l;
        right_in = r;
        ch_sel = cs;
        mode = md;
        sample_valid = 1'b1;
        model_push(l, r, cs, md, cyc + 3);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_check(input string name, input logic [31:0] l, input logic [31:0] r,
                               input logic [1:0] cs, input logic [1:0] md,
                               input int exp_lvl, input int exp_leds, input int exp_clip);
        drive(l, r, cs, md);
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        if (exp_lvl >= 0)  check({name, "_level"}, {28'd0, level}, exp_lvl);
        if (exp_leds >= 0) check({name, "_leds"}, {22'd0, leds}, exp_leds);
        if (exp_clip >= 0) check({name, "_clip"}, {31'd0, clip}, exp_clip);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_leds", {22'd0, leds}, 32'd0);
        check("rst_level", {28'd0, level}, 32'd0);
        check("rst_clip", {31'd0, clip}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    int pk_tab[17] = '{'h03F, 'h020, 'h020, 'h020, 'h020, 'h010, 'h010, 'h008, 'h008,
                       'h004, 'h004, 'h002, 'h002, 'h001, 'h001, 'h000, 'h000};
    int dc_tab[26] = '{10, 10, 10, 10, 10, 9, 9, 8, 8, 7, 7, 6, 6, 5, 5, 4, 4,
                       3, 3, 2, 2, 1, 1, 0, 0, 0};
    int cl_hit[12] = '{1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
    int cl_exp[12] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 0};
    logic [31:0] bb_l[8] = '{32'h00040001, 32'h08000001, 32'hFFF00000, 32'h00000000,
                             32'h00800001, 32'h01000000, 32'h80000001, 32'h00100001};
    logic [31:0] bb_r[8] = '{32'h00200001, 32'h00000010, 32'h00080001, 32'h04000001,
                             32'h00000000, 32'hFE000000, 32'h00000001, 32'h00020000};

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("init_leds", {22'd0, leds}, 32'd0);
        check("init_level", {28'd0, level}, 32'd0);
        check("init_clip", {31'd0, clip}, 32'd0);
        check("init_out_valid", {31'd0, out_valid}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // threshold edges, mode 0, left channel
        pulse_check("thr_2p18", 32'h00040000, 0, 2'd0, 2'd0, 0, 'h000, 0);
        pulse_check("thr_2p18p1", 32'h00040001, 0, 2'd0, 2'd0, 1, 'h001, 0);
        pulse_check("thr_2p27", 32'h08000000, 0, 2'd0, 2'd0, 9, 'h1FF, 0);
        pulse_check("thr_2p27p1", 32'h08000001, 0, 2'd0, 2'd0, 10, 'h3FF, 0);
        pulse_check("thr_neg", -32'sd262145, 0, 2'd0, 2'd0, 1, 'h001, 0);

        // channel select and sign handling
        pulse_check("ch_right", 32'h08000001, 32'h00080001, 2'd1, 2'd0, 2, 'h003, 0);
        pulse_check("ch_max3", 32'h00000010, -32'sd4194305, 2'd3, 2'd0, 5, 'h01F, 0);
        pulse_check("ch_max2", -32'sd1048577, 32'h00000010, 2'd2, 2'd0, 3, 'h007, 0);
        pulse_check("most_neg", 32'h80000000, 0, 2'd2, 2'd0, 10, 'h3FF, 1);

        // peak hold, mode 1
        do_reset();
        for (int i = 0; i < 17; i++)
            pulse_check("peak_hold", (i == 0) ? 32'h00800001 : 32'h0, 0, 2'd0, 2'd1,
                        -1, pk_tab[i], -1);

        // decaying bar, mode 2
        do_reset();
        for (int i = 0; i < 26; i++)
            pulse_check("decay", (i == 0) ? 32'h08000001 : 32'h0, 0, 2'd0, 2'd2,
                        dc_tab[i], -1, -1);

        // clip stretch and restart
        do_reset();
        for (int i = 0; i < 12; i++)
            pulse_check("clip_stretch", (cl_hit[i] != 0) ? 32'h7FFFFFFF : 32'h0, 0, 2'd0, 2'd0,
                        -1, -1, cl_exp[i]);

        // back-to-back strobes with mixed channel and mode
        for (int i = 0; i < 8; i++)
            drive(bb_l[i], bb_r[i], 2'(i), 2'(i >> 1));
        sample_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // reset in the middle of a stream
        drive(32'h08000001, 0, 2'd0, 2'd0);
        drive(32'h08000001, 0, 2'd0, 2'd0);
        drive(32'h08000001, 0, 2'd0, 2'd0);
        sample_valid = 1'b0;
        #2;
        check("pre_rst_level", {28'd0, level}, 32'd10);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_leds", {22'd0, leds}, 32'd0);
        check("mid_rst_level", {28'd0, level}, 32'd0);
        check("mid_rst_clip", {31'd0, clip}, 32'd0);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        pulse_check("post_rst", 32'h00040001, 0, 2'd0, 2'd0, 1, 'h001, 0);

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
